// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding, fixed-latency byte-addressable data memory.
// A request is captured on acceptance, the access is performed when the latency
// counter expires, and the response is held until the requester consumes it.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 64,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [3:0]    count;
    logic          cap_write;
    logic [63:0]   cap_addr;
    logic [1:0]    cap_size;
    logic [63:0]   cap_wdata;
    logic [7:0]    mem [DEPTH_BYTES];

    logic          req_fire;
    logic          resp_fire;
    logic          commit;
    logic [3:0]    nbytes;
    logic [AW-1:0] base_idx;
    logic [64:0]   end_addr;
    logic          access_err;
    logic [63:0]   load_data;

    assign req_fire  = req_valid && req_ready;
    assign resp_fire = resp_valid && resp_ready;
    assign commit    = (state == WAIT) && (count == 4'd1);

    // Access geometry and error detection for the captured request; the end
    // address is computed one bit wider so huge addresses cannot wrap into range.
    always_comb begin
        nbytes     = 4'd1 << cap_size;
        base_idx   = cap_addr[AW-1:0];
        end_addr   = {1'b0, cap_addr} + 65'(nbytes);
        access_err = ((cap_addr[3:0] & (nbytes - 4'd1)) != 4'd0) ||
                     (end_addr > 65'(DEPTH_BYTES));
    end

    // Little-endian gather of the addressed bytes, zero above the access size.
    always_comb begin
        load_data = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < nbytes) begin
                load_data[8*i +: 8] = mem[base_idx + AW'(i)];
            end
        end
    end

    // State register; reset always returns to IDLE and discards any request.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake outputs; req_ready is held low while reset is asserted.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_fire) begin
                    next_state = WAIT;
                end
            end
            WAIT: begin
                if (count == 4'd1) begin
                    next_state = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_fire) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Request capture, latency countdown and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= 4'd0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_size   <= '0;
            cap_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == IDLE && req_fire) begin
                count     <= 4'(LATENCY);
                cap_write <= req_write;
                cap_addr  <= req_addr;
                cap_size  <= req_size;
                cap_wdata <= req_wdata;
            end else if (state == WAIT) begin
                count <= count - 4'd1;
            end
            if (commit) begin
                resp_err   <= access_err;
                resp_rdata <= (cap_write || access_err) ? 64'd0 : load_data;
            end
        end
    end

    // Storage array; a store only lands on the commit edge and only when legal.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int j = 0; j < DEPTH_BYTES; j++) begin
                mem[j] <= 8'h00;
            end
        end else if (commit && cap_write && !access_err) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < nbytes) begin
                    mem[base_idx + AW'(i)] <= cap_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed testbench for data_mem_responder with default parameters.
module tb_data_mem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [63:0] req_addr;
    logic [1:0]  req_size;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int tests_run;
    int tests_failed;

    logic [63:0] got_rdata;
    logic        got_err;
    int          got_edges;

    data_mem_responder #(
        .DEPTH_BYTES(64),
        .LATENCY(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_size(req_size),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_rdata(resp_rdata),
        .resp_err(resp_err)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [63:0] observed,
                                input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction. Called 1 time unit after a rising edge.
    // hold_cycles stalls resp_ready in RESP; scramble keeps req_valid high and
    // changes address/data every cycle while the request is outstanding.
    task automatic apply_stimulus(input logic write, input logic [63:0] addr,
                                  input logic [1:0] size, input logic [63:0] wdata,
                                  input int hold_cycles, input logic scramble,
                                  output logic [63:0] rdata, output logic err,
                                  output int edges);
        logic [63:0] held_rdata;
        logic        held_err;
        req_write = write;
        req_addr  = addr;
        req_size  = size;
        req_wdata = wdata;
        req_valid = 1'b1;
        check_output("req_ready before accept", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        if (!scramble) req_valid = 1'b0;
        edges = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            edges++;
            #1;
            if (resp_valid) break;
            check_output("req_ready while waiting", 64'(req_ready), 64'd0);
            if (scramble) begin
                req_addr  = {$urandom, $urandom};
                req_wdata = {$urandom, $urandom};
                req_write = ~req_write;
            end
        end
        req_valid = 1'b0;
        check_output("resp_valid arrives", 64'(resp_valid), 64'd1);
        held_rdata = resp_rdata;
        held_err   = resp_err;
        for (int h = 0; h < hold_cycles; h++) begin
            @(posedge clk);
            #1;
            check_output("stall resp_valid", 64'(resp_valid), 64'd1);
            check_output("stall resp_rdata", resp_rdata, held_rdata);
            check_output("stall resp_err", 64'(resp_err), 64'(held_err));
            check_output("stall req_ready", 64'(req_ready), 64'd0);
        end
        rdata = resp_rdata;
        err   = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check_output("req_ready after handshake", 64'(req_ready), 64'd1);
        check_output("resp_valid after handshake", 64'(resp_valid), 64'd0);
    endtask

    // Directed sequence.
    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_size   = '0;
        req_wdata  = '0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check_output("reset req_ready", 64'(req_ready), 64'd0);
        check_output("reset resp_valid", 64'(resp_valid), 64'd0);
        check_output("reset resp_rdata", resp_rdata, 64'd0);
        check_output("reset resp_err", 64'(resp_err), 64'd0);
        reset = 1'b0;
        #1;
        check_output("req_ready after reset", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Store then load a double word, checking the latency.
        apply_stimulus(1'b1, 64'h8, 2'd3, 64'h1122334455667788, 0, 1'b0,
                       got_rdata, got_err, got_edges);
        check_output("store8 err", 64'(got_err), 64'd0);
        check_output("store8 rdata", got_rdata, 64'd0);
        check_output("store8 latency", 64'(got_edges), 64'd2);
        apply_stimulus(1'b0, 64'h8, 2'd3, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("load8 rdata", got_rdata, 64'h1122334455667788);
        check_output("load8 err", 64'(got_err), 64'd0);
        check_output("load8 latency", 64'(got_edges), 64'd2);

        // Sub-word store and loads.
        apply_stimulus(1'b1, 64'h3, 2'd0, 64'hFFFF_FFFF_FFFF_FFAB, 0, 1'b0,
                       got_rdata, got_err, got_edges);
        check_output("storeb err", 64'(got_err), 64'd0);
        apply_stimulus(1'b0, 64'h0, 2'd2, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("loadw0 rdata", got_rdata, 64'h00000000AB000000);
        apply_stimulus(1'b0, 64'h3, 2'd0, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("loadb3 rdata", got_rdata, 64'h00000000000000AB);

        // Misaligned load.
        apply_stimulus(1'b0, 64'h5, 2'd1, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("misaligned load err", 64'(got_err), 64'd1);
        check_output("misaligned load rdata", got_rdata, 64'd0);

        // Misaligned store must not touch memory.
        apply_stimulus(1'b1, 64'h9, 2'd1, 64'hFFFF, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("misaligned store err", 64'(got_err), 64'd1);
        apply_stimulus(1'b0, 64'h8, 2'd3, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("after misaligned store", got_rdata, 64'h1122334455667788);

        // Out-of-range stores leave the last double word intact.
        apply_stimulus(1'b1, 64'h38, 2'd3, 64'hCAFEBABEDEADBEEF, 0, 1'b0,
                       got_rdata, got_err, got_edges);
        check_output("store last dword err", 64'(got_err), 64'd0);
        apply_stimulus(1'b1, 64'h40, 2'd0, 64'h55, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("oor store err", 64'(got_err), 64'd1);
        apply_stimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 2'd3, 64'h0, 0, 1'b0,
                       got_rdata, got_err, got_edges);
        check_output("huge addr store err", 64'(got_err), 64'd1);
        apply_stimulus(1'b0, 64'h38, 2'd3, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("last dword unchanged", got_rdata, 64'hCAFEBABEDEADBEEF);
        check_output("last dword err", 64'(got_err), 64'd0);

        // Backpressure: five stalled cycles in RESP.
        apply_stimulus(1'b0, 64'h8, 2'd3, 64'h0, 5, 1'b0, got_rdata, got_err, got_edges);
        check_output("stalled load rdata", got_rdata, 64'h1122334455667788);

        // Reset one cycle after accepting a store: the store is discarded.
        req_write = 1'b1;
        req_addr  = 64'h10;
        req_size  = 2'd0;
        req_wdata = 64'hFF;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("midop accepted", 64'(req_ready), 64'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_output("midop reset resp_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        #1;
        check_output("midop req_ready", 64'(req_ready), 64'd1);
        @(posedge clk);
        #1;
        repeat (3) @(posedge clk);
        #1;
        check_output("midop no late resp", 64'(resp_valid), 64'd0);
        apply_stimulus(1'b0, 64'h10, 2'd0, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("midop store discarded", got_rdata, 64'd0);

        // Reset and req_valid on the same edge: nothing accepted.
        reset     = 1'b1;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 64'h0;
        req_size  = 2'd0;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check_output("reset priority req_ready", 64'(req_ready), 64'd1);
        check_output("reset priority resp_valid", 64'(resp_valid), 64'd0);

        // Inputs changing during WAIT do not affect the captured store.
        apply_stimulus(1'b1, 64'h20, 2'd3, 64'h0123456789ABCDEF, 0, 1'b1,
                       got_rdata, got_err, got_edges);
        check_output("scrambled store err", 64'(got_err), 64'd0);
        apply_stimulus(1'b0, 64'h20, 2'd3, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("scrambled store data", got_rdata, 64'h0123456789ABCDEF);
        apply_stimulus(1'b0, 64'h38, 2'd3, 64'h0, 0, 1'b0, got_rdata, got_err, got_edges);
        check_output("after reset last dword", got_rdata, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
